ov7670_frame_capture: RTL and testbench
=======================================

# ov7670_frame_capture

Parametrised successor to the OV7670 pixel-to-memory write controller. Sits between the OV7670 parallel bus (pclk domain) and the frame-buffer write port. Adds a frame-synchronous state machine that never captures partial frames, power-of-two decimation, a YUV422 luma-to-grey mode, frame start/done strobes, and optional status counters.

## Interface
- `H_PIX`, 640: active pixels per line, counted in sensor pixels of 2 bytes each.
- `V_LINES`, 480: active lines per frame.
- `DECIM`, 2: decimation factor in both axes; legal values are 1, 2 and 4.
- `ADDR_W`, `$clog2((H_PIX/DECIM)*(V_LINES/DECIM))`: write address width.

- `pclk` in 1: sensor pixel clock; the only clock.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `enable` in 1: capture request; sampled only at frame start.
- `fmt` in 1: 0 = RGB565 pass-through, 1 = YUV422 (YUYV) luma to grey RGB565; latched at frame start.
- `href` in 1: line-valid from the sensor.
- `vsync` in 1: frame sync from the sensor, active high.
- `data` in 8: sensor byte.
- `we` out 1: frame-buffer write strobe, 1 cycle.
- `wAddr` out ADDR_W: frame-buffer address.
- `wdata` out 16: RGB565 pixel.
- `frame_start` out 1: 1-cycle pulse on capture start.
- `frame_done` out 1: 1-cycle pulse on capture end.
- `busy` out 1: high while in FRAME.
- `frame_cnt` out 16: completed frames (macro-gated).
- `line_err` out 1: sticky geometry error (macro-gated).

## Operation
- Input registers: `vsync_d` and `href_d` are 1-cycle delayed copies used for edge detection. `vs_rise` = vsync & !vsync_d. `vs_fall` = !vsync & vsync_d. `hr_fall` = !href & href_d.
- FSM states are IDLE, SYNC and FRAME. IDLE is the reset state.
  - IDLE → SYNC on `vs_rise`.
  - SYNC → FRAME on `vs_fall` when `enable`=1. On that transition: pulse `frame_start`, latch `fmt`, clear x, y, byte phase and address.
  - SYNC → IDLE on `vs_fall` when `enable`=0.
  - FRAME → SYNC on `vs_rise`. On that transition: pulse `frame_done`.
  - Deasserting `enable` mid-frame has no effect; the current frame completes.
- Byte phase `ph` is active only in FRAME while href=1.
  - It toggles on every href-high cycle.
  - It is forced to 0 while href=0.
  - ph=0 captures byte A; ph=1 captures byte B and completes one pixel at column x.
- Pixel completion:
  - x increments on each completed pixel and saturates at H_PIX.
  - On `hr_fall` in FRAME: x ← 0, y ← y+1, saturating at V_LINES.
- Write condition: pixel completes and x<H_PIX and y<V_LINES and x%DECIM==0 and y%DECIM==0.
  - Modulo uses low bits only, since DECIM is a power of two.
  - Pixels and lines beyond the active window are dropped.
- Data path:
  - fmt=0: wdata = {A, B}.
  - fmt=1: Y = A. wdata = {Y[7:3], Y[7:2], Y[7:3]}. Byte B (U or V) is discarded.
- Address:
  - The first write of a frame uses `wAddr`=0.
  - `wAddr` increments by 1 after each write.
  - `wAddr` never exceeds (H_PIX/DECIM)*(V_LINES/DECIM)−1; further writes are impossible by the window check.
- Outputs in IDLE/SYNC: `we`=0; `wAddr` holds its last value.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Write latency: `we`, `wAddr` and `wdata` are registered. They become valid together in the cycle after the ph=1 byte is sampled. `we` is high for exactly 1 cycle.
- Strobes: `frame_start` and `frame_done` are high in the cycle after the sampled vsync edge (1-cycle edge-detect latency plus a registered output).
- `busy` is registered and asserts in the same cycle as `frame_start`.
- Simultaneous `vs_rise` and a pixel completion in FRAME: the pixel write is performed, then the state goes to SYNC.
- Odd byte count on a line: the trailing ph=0 byte is discarded at `hr_fall`.
- Reset asserted mid-frame: immediate return to IDLE, outputs 0. Capture resumes only after a full `vs_rise`/`vs_fall` sequence.

## Configuration
- Macro: `OV7670_CAPTURE_STATUS_EN`.
- Defined:
  - `frame_cnt` increments (wrapping at 16 bits) on every `frame_done`.
  - `line_err` sets and stays set until reset when either:
    - a line ends (`hr_fall`) with x ≠ H_PIX or an odd byte count, or
    - `frame_done` occurs with y ≠ V_LINES.
- Undefined: `frame_cnt` = 0 and `line_err` = 0 constantly. No counter or comparator logic is synthesised.

## Test plan
- Reset/sync, with H_PIX=8, V_LINES=4, DECIM=1. Stream a full frame starting mid-frame after reset. Required: no `we` until after the first complete vsync pulse. The next frame gives 32 writes with `wAddr` 0→31, one `frame_start`, one `frame_done`.
- RGB565 data, fmt=0. Bytes 0xF8, 0x1F for pixel 0. Required: `wdata`=0xF81F at `wAddr`=0, with `we` 1 cycle after the second byte.
- Grey mode, fmt=1. Bytes Y=0xFF, U=0x80. Required: `wdata`=0xFFFF. With Y=0x80: `wdata`=0x8410.
- Decimation, DECIM=2, same geometry. Required: exactly 8 writes (`wAddr` 0..7), taken only at even x and even y.
- `enable` low at `vs_fall`: no writes and no `frame_start`; state returns to IDLE. Drop `enable` mid-frame: that frame still completes with `frame_done`.
- With `OV7670_CAPTURE_STATUS_EN`: a 7-pixel line sets `line_err`=1, which persists. After 3 frames, `frame_cnt`=3. Without the macro, both read 0.

Source files
------------

// File: rtl/ov7670_frame_capture.sv
// OV7670 byte stream to frame-buffer write port, frame-synchronous with decimation and grey mode.
// Optional frame counter / geometry error flag enabled by OV7670_CAPTURE_STATUS_EN.
module ov7670_frame_capture #(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480,
    parameter int DECIM   = 2,
    parameter int ADDR_W  = $clog2((H_PIX/DECIM)*(V_LINES/DECIM))
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fmt,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wdata,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              line_err
);

    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam logic [XW-1:0] X_MAX = XW'(H_PIX);
    localparam logic [YW-1:0] Y_MAX = YW'(V_LINES);
    localparam logic [XW-1:0] X_MSK = XW'(DECIM - 1);
    localparam logic [YW-1:0] Y_MSK = YW'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, SYNC, FRAME} state_t;

    state_t              state_q, state_d;
    logic                vsync_dly_q, href_dly_q;
    logic                ph_q, ph_d;
    logic [7:0]          a_q, a_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic                fmt_q, fmt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                fs_q, fs_d;
    logic                fd_q, fd_d;
    logic                busy_q, busy_d;

    logic vs_rise, vs_fall, hr_fall, in_win;

    assign vs_rise = vsync & ~vsync_dly_q;
    assign vs_fall = ~vsync & vsync_dly_q;
    assign hr_fall = ~href & href_dly_q;
    assign in_win  = (x_q < X_MAX) && (y_q < Y_MAX) &&
                     ((x_q & X_MSK) == '0) && ((y_q & Y_MSK) == '0);

    always_comb begin
        state_d = state_q;
        ph_d    = 1'b0;
        a_d     = a_q;
        x_d     = x_q;
        y_d     = y_q;
        fmt_d   = fmt_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        fs_d    = 1'b0;
        fd_d    = 1'b0;

        // Pixel path runs on the current state so a pixel finishing on vs_rise still lands.
        if (state_q == FRAME) begin
            if (href) begin
                ph_d = ~ph_q;
                if (!ph_q) begin
                    a_d = data;
                end else begin
                    if (x_q != X_MAX) x_d = x_q + 1'b1;
                    if (in_win) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        addr_d  = addr_q + 1'b1;
                        wdata_d = fmt_q ? {a_q[7:3], a_q[7:2], a_q[7:3]} : {a_q, data};
                    end
                end
            end else if (hr_fall) begin
                x_d = '0;
                if (y_q != Y_MAX) y_d = y_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: if (vs_rise) state_d = SYNC;
            SYNC: begin
                if (vs_fall) begin
                    if (enable) begin
                        state_d = FRAME;
                        fs_d    = 1'b1;
                        fmt_d   = fmt;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FRAME: begin
                if (vs_rise) begin
                    state_d = SYNC;
                    fd_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == FRAME);
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            vsync_dly_q <= 1'b0;
            href_dly_q  <= 1'b0;
            ph_q        <= 1'b0;
            a_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            fmt_q       <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            fs_q        <= 1'b0;
            fd_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_dly_q <= vsync;
            href_dly_q  <= href;
            ph_q        <= ph_d;
            a_q         <= a_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fmt_q       <= fmt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            fs_q        <= fs_d;
            fd_q        <= fd_d;
            busy_q      <= busy_d;
        end
    end

    assign we          = we_q;
    assign wAddr       = waddr_q;
    assign wdata       = wdata_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign busy        = busy_q;

`ifdef OV7670_CAPTURE_STATUS_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    // ph_q still holds the last line's parity in the hr_fall cycle, so 1 means an odd byte count.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (fd_d) cnt_d = cnt_q + 16'd1;
        if ((state_q == FRAME) && hr_fall && ((x_q != X_MAX) || ph_q)) err_d = 1'b1;
        if (fd_d && (y_q != Y_MAX)) err_d = 1'b1;
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign frame_cnt = cnt_q;
    assign line_err  = err_q;
`else
    assign frame_cnt = 16'h0;
    assign line_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Directed bench: 8x4 geometry, DECIM=1 and DECIM=2 instances sharing one sensor stream.
module tb_ov7670_frame_capture;

    localparam int H = 8;
    localparam int V = 4;
`ifdef OV7670_CAPTURE_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic pclk = 1'b0, reset = 1'b0, enable = 1'b0, fmt = 1'b0, href = 1'b0, vsync = 1'b0;
    logic [7:0] data = 8'h00;

    logic we1, fs1, fd1, busy1, err1, we2, fs2, fd2, busy2, err2;
    logic [4:0] wAddr1;
    logic [2:0] wAddr2;
    logic [15:0] wdata1, wdata2, cnt1, cnt2;

    ov7670_frame_capture #(.H_PIX(H), .V_LINES(V), .DECIM(1)) u1 (
        .pclk(pclk), .reset(reset), .enable(enable), .fmt(fmt), .href(href), .vsync(vsync),
        .data(data), .we(we1), .wAddr(wAddr1), .wdata(wdata1), .frame_start(fs1),
        .frame_done(fd1), .busy(busy1), .frame_cnt(cnt1), .line_err(err1));

    ov7670_frame_capture #(.H_PIX(H), .V_LINES(V), .DECIM(2)) u2 (
        .pclk(pclk), .reset(reset), .enable(enable), .fmt(fmt), .href(href), .vsync(vsync),
        .data(data), .we(we2), .wAddr(wAddr2), .wdata(wdata2), .frame_start(fs2),
        .frame_done(fd2), .busy(busy2), .frame_cnt(cnt2), .line_err(err2));

    always #5 pclk = ~pclk;

    int checks = 0, errors = 0;
    int wcnt1 = 0, wcnt2 = 0, fs_cnt = 0, fd_cnt = 0;
    int ea1 = 0, ea2 = 0;
    bit cap = 1'b0, in_frame = 1'b0, fmt_v = 1'b0;
    logic [7:0] a0 = 8'h00, b0 = 8'h00;
    logic [15:0] e0 = 16'h0000;

    always @(negedge pclk) begin
        if (we1 === 1'b1) wcnt1++;
        if (we2 === 1'b1) wcnt2++;
        if (fs1 === 1'b1) fs_cnt++;
        if (fd1 === 1'b1) fd_cnt++;
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_a(input int y, input int x);
        logic [7:0] r;
        r = {y[1:0], x[2:0], 3'b101};
        if (y == 0 && x == 0) r = a0;
        return r;
    endfunction

    function automatic logic [7:0] byte_b(input int y, input int x);
        logic [7:0] r;
        r = 8'hC0 | 8'(x);
        if (y == 0 && x == 0) r = b0;
        return r;
    endfunction

    // Pixel (0,0) uses a hand-computed expected word; the rest follow the format rules.
    function automatic logic [15:0] exp_pix(input int y, input int x);
        logic [7:0] a;
        logic [15:0] r;
        a = byte_a(y, x);
        r = fmt_v ? {a[7:3], a[7:2], a[7:3]} : {a, byte_b(y, x)};
        if (y == 0 && x == 0) r = e0;
        return r;
    endfunction

    task automatic send_line(input int y, input int nbytes);
        int x;
        bit w1, w2;
        for (int i = 0; i < nbytes; i++) begin
            x = i / 2;
            href = 1'b1;
            data = (i % 2 == 0) ? byte_a(y, x) : byte_b(y, x);
            tick();
            if (i % 2 == 1) begin
                w1 = cap && (x < H) && (y < V);
                w2 = w1 && (x % 2 == 0) && (y % 2 == 0);
                chk_b("we_d1", we1, w1);
                if (w1) begin
                    chk_w("addr_d1", 16'(wAddr1), 16'(ea1));
                    chk_w("data_d1", wdata1, exp_pix(y, x));
                    ea1++;
                end
                chk_b("we_d2", we2, w2);
                if (w2) begin
                    chk_w("addr_d2", 16'(wAddr2), 16'(ea2));
                    chk_w("data_d2", wdata2, exp_pix(y, x));
                    ea2++;
                end
            end
        end
        href = 1'b0;
        data = 8'h00;
        repeat (3) tick();
    endtask

    task automatic vpulse(input bit en, input bit f);
        enable = en;
        fmt    = f;
        vsync  = 1'b1;
        tick();
        chk_b("frame_done", fd1, in_frame);
        chk_b("busy_sync", busy1, 1'b0);
        repeat (2) tick();
        chk_b("frame_done_1cyc", fd1, 1'b0);
        vsync = 1'b0;
        tick();
        chk_b("frame_start", fs1, en);
        chk_b("busy_start", busy1, en);
        tick();
        chk_b("frame_start_1cyc", fs1, 1'b0);
        cap = en; in_frame = en; fmt_v = f; ea1 = 0; ea2 = 0;
    endtask

    task automatic full_frame(input bit en, input bit f);
        vpulse(en, f);
        for (int y = 0; y < V; y++) send_line(y, 2 * H);
    endtask

    initial begin
        repeat (3) tick();
        chk_b("rst_we", we1, 1'b0);
        chk_w("rst_addr", 16'(wAddr1), 16'h0);
        chk_w("rst_data", wdata1, 16'h0);
        chk_b("rst_fs", fs1, 1'b0);
        chk_b("rst_fd", fd1, 1'b0);
        chk_b("rst_busy", busy1, 1'b0);
        chk_w("rst_cnt", cnt1, 16'h0);
        chk_b("rst_err", err1, 1'b0);
        reset = 1'b1;
        tick();

        // Tail of a frame already in flight when reset released: ignored.
        send_line(2, 16);
        send_line(3, 16);
        chk_i("no_we_before_sync", wcnt1, 0);

        a0 = 8'hF8; b0 = 8'h1F; e0 = 16'hF81F;
        full_frame(1'b1, 1'b0);
        chk_i("frame_a_writes_d1", wcnt1, 32);
        chk_i("frame_a_writes_d2", wcnt2, 8);
        chk_w("frame_a_last_addr", 16'(wAddr1), 16'd31);

        a0 = 8'hFF; b0 = 8'h80; e0 = 16'hFFFF;
        full_frame(1'b1, 1'b1);
        chk_i("frame_b_writes_d1", wcnt1, 64);

        // enable drops after line 0; the frame must still complete.
        a0 = 8'h80; b0 = 8'h80; e0 = 16'h8410;
        vpulse(1'b1, 1'b1);
        send_line(0, 16);
        enable = 1'b0;
        for (int y = 1; y < V; y++) send_line(y, 16);
        chk_i("frame_c_writes_d1", wcnt1, 96);

        full_frame(1'b0, 1'b0);
        chk_i("disabled_writes_d1", wcnt1, 96);
        chk_i("disabled_writes_d2", wcnt2, 24);
        chk_i("frame_start_count", fs_cnt, 3);
        chk_i("frame_done_count", fd_cnt, 3);
        chk_b("idle_busy", busy1, 1'b0);
        chk_w("addr_hold_d1", 16'(wAddr1), 16'd31);
        chk_w("addr_hold_d2", 16'(wAddr2), 16'd7);
        chk_w("frame_cnt_3", cnt1, STAT ? 16'd3 : 16'd0);
        chk_b("line_err_clean", err1, 1'b0);

        // Reset in the middle of a captured frame.
        a0 = 8'hF8; b0 = 8'h1F; e0 = 16'hF81F;
        vpulse(1'b1, 1'b0);
        send_line(0, 16);
        send_line(1, 16);
        reset = 1'b0;
        #2;
        chk_b("midrst_busy", busy1, 1'b0);
        chk_b("midrst_we", we1, 1'b0);
        chk_w("midrst_addr", 16'(wAddr1), 16'h0);
        chk_w("midrst_cnt", cnt1, 16'h0);
        tick();
        reset = 1'b1;
        cap = 1'b0; in_frame = 1'b0;
        send_line(2, 16);
        send_line(3, 16);
        chk_i("midrst_writes_d1", wcnt1, 112);
        chk_i("midrst_writes_d2", wcnt2, 28);

        // Line 1 is 7.5 pixels: odd trailing byte dropped, geometry error flagged.
        vpulse(1'b1, 1'b0);
        send_line(0, 16);
        send_line(1, 15);
        chk_b("line_err_set", err1, STAT);
        send_line(2, 16);
        send_line(3, 16);
        vpulse(1'b0, 1'b0);
        chk_i("short_frame_writes_d1", wcnt1, 143);
        chk_i("short_frame_writes_d2", wcnt2, 36);
        chk_b("line_err_sticky", err1, STAT);
        chk_w("frame_cnt_after_rst", cnt1, STAT ? 16'd1 : 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
